// File: rtl/crop_distributor.sv
// crop_distributor: steers a back-to-back crop pixel stream to per-crop AXI-Stream lanes
// through a registered output stage with a one-entry skid buffer.
module crop_distributor #(
  parameter int OUT_ROWS  = 20,
  parameter int OUT_COLS  = 20,
  parameter int NUM_CROPS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [7:0]           s_axis_tdata,
  output logic [NUM_CROPS-1:0] m_axis_tvalid,
  input  logic [NUM_CROPS-1:0] m_axis_tready,
  output logic [7:0]           m_axis_tdata [NUM_CROPS-1:0],
  output logic [NUM_CROPS-1:0] m_axis_tlast,
  output logic [2:0]           crop_idx,
  output logic                 frame_done
);
  localparam int NPIX = OUT_ROWS * OUT_COLS;
  localparam int CW   = $clog2(NPIX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    crop_q, crop_d, or_dest_q, or_dest_d, sr_dest_q, sr_dest_d;
  logic [7:0]    or_data_q, or_data_d, sr_data_q, sr_data_d;
  logic          or_v_q, or_v_d, or_last_q, or_last_d;
  logic          sr_v_q, sr_v_d, sr_last_q, sr_last_d;
  logic          rdy_q, rdy_d, fd_q, fd_d;
  logic          s_hs, m_hs, in_last, or_free, ld_sr2or, ld_in2or, ld_in2sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      crop_q    <= '0;
      or_v_q    <= 1'b0;
      or_last_q <= 1'b0;
      or_dest_q <= '0;
      or_data_q <= '0;
      sr_v_q    <= 1'b0;
      sr_last_q <= 1'b0;
      sr_dest_q <= '0;
      sr_data_q <= '0;
      rdy_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      crop_q    <= crop_d;
      or_v_q    <= or_v_d;
      or_last_q <= or_last_d;
      or_dest_q <= or_dest_d;
      or_data_q <= or_data_d;
      sr_v_q    <= sr_v_d;
      sr_last_q <= sr_last_d;
      sr_dest_q <= sr_dest_d;
      sr_data_q <= sr_data_d;
      rdy_q     <= rdy_d;
      fd_q      <= fd_d;
    end
  end

  always_comb begin
    m_hs = 1'b0;
    for (int i = 0; i < NUM_CROPS; i++)
      if (or_dest_q == 3'(i)) m_hs = or_v_q && m_axis_tready[i];
    s_hs     = s_axis_tvalid && rdy_q;
    in_last  = cnt_q == CW'(NPIX - 1);
    cnt_d    = s_hs ? (in_last ? '0 : cnt_q + CW'(1)) : cnt_q;
    crop_d   = (s_hs && in_last) ? (crop_q == 3'(NUM_CROPS - 1) ? 3'd0 : crop_q + 3'd1) : crop_q;
    // SR is only ever full while s_axis_tready is low, so SR->OR and an accept never collide
    or_free  = !or_v_q || m_hs;
    ld_sr2or = or_free && sr_v_q;
    ld_in2or = or_free && !sr_v_q && s_hs;
    ld_in2sr = !or_free && s_hs;
    or_v_d    = or_free ? (sr_v_q || s_hs) : 1'b1;
    or_data_d = ld_sr2or ? sr_data_q : ld_in2or ? s_axis_tdata : or_data_q;
    or_dest_d = ld_sr2or ? sr_dest_q : ld_in2or ? crop_q : or_dest_q;
    or_last_d = ld_sr2or ? sr_last_q : ld_in2or ? in_last : or_last_q;
    sr_v_d    = ld_in2sr || (sr_v_q && !ld_sr2or);
    sr_data_d = ld_in2sr ? s_axis_tdata : sr_data_q;
    sr_dest_d = ld_in2sr ? crop_q : sr_dest_q;
    sr_last_d = ld_in2sr ? in_last : sr_last_q;
    rdy_d     = !sr_v_d;
    fd_d      = m_hs && or_last_q && or_dest_q == 3'(NUM_CROPS - 1);
  end

  always_comb begin
    for (int i = 0; i < NUM_CROPS; i++) begin
      m_axis_tvalid[i] = or_v_q && or_dest_q == 3'(i);
      m_axis_tlast[i]  = or_v_q && or_dest_q == 3'(i) && or_last_q;
      m_axis_tdata[i]  = or_data_q;
    end
    s_axis_tready = rdy_q;
    crop_idx      = crop_q;
    frame_done    = fd_q;
  end
endmodule

// File: tb/tb_crop_distributor.sv
// tb_crop_distributor: directed and random checks of crop_distributor with default 20x20x3 geometry.
module tb_crop_distributor;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = '0;
  logic [2:0] m_axis_tvalid;
  logic [2:0] m_axis_tready = '0;
  logic [7:0] m_axis_tdata [2:0];
  logic [2:0] m_axis_tlast;
  logic [2:0] crop_idx;
  logic       frame_done;

  int total = 0;
  int bad = 0;
  int fd_count = 0;
  logic [7:0] dval = '0;

  logic [10:0] sbq [$];
  int mcnt = 0;
  int mcrop = 0;
  logic fd_exp = 1'b0;
  logic prev_hold = 1'b0;
  logic [2:0] prev_v = '0;
  logic [2:0] prev_l = '0;
  logic [7:0] prev_d = '0;

  crop_distributor dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .crop_idx(crop_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Scoreboard: beats leave in acceptance order, so one queue tagged with the lane suffices.
  always @(negedge clk) begin
    if (!reset_n) begin
      sbq.delete();
      mcnt = 0;
      mcrop = 0;
      fd_exp = 1'b0;
      prev_hold = 1'b0;
    end else begin
      total++;
      if (frame_done !== fd_exp) begin
        bad++;
        $display("FAIL frame_done: got %b want %b", frame_done, fd_exp);
      end
      if (frame_done === 1'b1) fd_count++;
      fd_exp = 1'b0;
      total++;
      if (!$onehot0(m_axis_tvalid) || (m_axis_tlast & ~m_axis_tvalid) != 3'b0) begin
        bad++;
        $display("FAIL onehot: valid=%b last=%b want one-hot valid, last within valid", m_axis_tvalid, m_axis_tlast);
      end
      if (prev_hold) begin
        total++;
        if (m_axis_tvalid !== prev_v || m_axis_tlast !== prev_l || m_axis_tdata[0] !== prev_d) begin
          bad++;
          $display("FAIL hold: got v=%b l=%b d=%h want v=%b l=%b d=%h", m_axis_tvalid, m_axis_tlast,
                   m_axis_tdata[0], prev_v, prev_l, prev_d);
        end
      end
      prev_hold = 1'b0;
      for (int l = 0; l < 3; l++) begin
        if (m_axis_tvalid[l] && !m_axis_tready[l]) begin
          prev_hold = 1'b1;
          prev_v = m_axis_tvalid;
          prev_l = m_axis_tlast;
          prev_d = m_axis_tdata[l];
        end
        if (m_axis_tvalid[l] && m_axis_tready[l]) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: lane %0d data %h with nothing expected", l, m_axis_tdata[l]);
          end else begin
            logic [10:0] e;
            e = sbq.pop_front();
            if ({2'(l), m_axis_tlast[l], m_axis_tdata[l]} !== e) begin
              bad++;
              $display("FAIL sb_beat: got lane=%0d last=%b data=%h want lane=%0d last=%b data=%h",
                       l, m_axis_tlast[l], m_axis_tdata[l], e[10:9], e[8], e[7:0]);
            end
            fd_exp = e[10:9] == 2'd2 && e[8];
          end
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        sbq.push_back({2'(mcrop), mcnt == 399, s_axis_tdata});
        mcnt++;
        if (mcnt == 400) begin
          mcnt = 0;
          mcrop = (mcrop + 1) % 3;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 3'b111;
    dval = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic send(input int n, input logic [2:0] mask, input bit rnd, output int acc);
    int cyc = 0;
    acc = 0;
    while (acc < n && cyc < 40000) begin
      @(posedge clk); #1;
      s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata = dval;
      m_axis_tready = rnd ? 3'($urandom_range(0, 7)) : mask;
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        acc++;
        dval++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h55;
    m_axis_tready = 3'b111;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (m_axis_tvalid !== 3'b000) begin bad++; $display("FAIL rst_mvalid: got %b want 000", m_axis_tvalid); end
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_sready: got %b want 0", s_axis_tready); end
    total++; if (crop_idx !== 3'd0) begin bad++; $display("FAIL rst_crop: got %0d want 0", crop_idx); end
    total++; if (m_axis_tlast !== 3'b000) begin bad++; $display("FAIL rst_tlast: got %b want 000", m_axis_tlast); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rel_sready0: got %b want 0", s_axis_tready); end
    @(negedge clk);
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rel_sready1: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_stream();
    logic [2:0] ev;
    int f0 = fd_count;
    for (int i = 0; i <= 1200; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = i < 1200;
      s_axis_tdata = 8'(i);
      m_axis_tready = 3'b111;
      @(negedge clk);
      total++;
      if (crop_idx !== 3'((i / 400) % 3)) begin bad++; $display("FAIL st_crop: i=%0d got %0d want %0d", i, crop_idx, (i / 400) % 3); end
      if (i < 1200) begin
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL st_sready: i=%0d got %b want 1", i, s_axis_tready); end
      end
      if (i > 0) begin
        ev = 3'b001 << ((i - 1) / 400);
        total++;
        if (m_axis_tvalid !== ev || m_axis_tdata[(i - 1) / 400] !== 8'(i - 1) ||
            m_axis_tlast !== (((i - 1) % 400 == 399) ? ev : 3'b000)) begin
          bad++;
          $display("FAIL st_out: pix %0d got v=%b d=%h l=%b want v=%b d=%h", i - 1, m_axis_tvalid,
                   m_axis_tdata[(i - 1) / 400], m_axis_tlast, ev, 8'(i - 1));
        end
      end
    end
    @(negedge clk);
    total++; if (frame_done !== 1'b1 || m_axis_tvalid !== 3'b000) begin bad++; $display("FAIL st_fd: got fd=%b v=%b want 1 000", frame_done, m_axis_tvalid); end
    @(negedge clk);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL st_fd_off: got %b want 0", frame_done); end
    total++; if (fd_count - f0 != 1) begin bad++; $display("FAIL st_fd_count: got %0d want 1", fd_count - f0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] base = dval;
    int acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = dval;
      m_axis_tready = 3'b110;
      @(negedge clk);
      if (c >= 2) begin
        total++;
        if (m_axis_tvalid !== 3'b001 || m_axis_tdata[0] !== base || m_axis_tlast !== 3'b000) begin
          bad++;
          $display("FAIL bp_hold: got v=%b d=%h l=%b want v=001 d=%h l=000", m_axis_tvalid, m_axis_tdata[0], m_axis_tlast, base);
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        acc++;
        dval++;
      end
    end
    total++; if (acc != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL bp_sready: got %b want 0", s_axis_tready); end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 3'b111;
    @(negedge clk);
    total++; if (m_axis_tdata[0] !== base) begin bad++; $display("FAIL bp_first: got %h want %h", m_axis_tdata[0], base); end
    @(negedge clk);
    total++; if (m_axis_tvalid !== 3'b001 || m_axis_tdata[0] !== base + 8'd1) begin bad++; $display("FAIL bp_second: got v=%b d=%h want 001 %h", m_axis_tvalid, m_axis_tdata[0], base + 8'd1); end
    @(negedge clk);
    total++; if (m_axis_tvalid !== 3'b000 || s_axis_tready !== 1'b1) begin bad++; $display("FAIL bp_empty: got v=%b r=%b want 000 1", m_axis_tvalid, s_axis_tready); end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL bp_queue: got %0d left want 0", sbq.size()); end
  endtask

  task automatic test_boundary();
    int acc;
    do_reset();
    send(399, 3'b111, 1'b0, acc);
    total++; if (acc != 399) begin bad++; $display("FAIL bd_pre: got %0d want 399", acc); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      s_axis_tvalid = c < 2;
      s_axis_tdata = dval;
      m_axis_tready = 3'b110;
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) dval++;
      if (c >= 3) begin
        total++;
        if (m_axis_tvalid !== 3'b001 || m_axis_tlast !== 3'b001 || m_axis_tdata[0] !== 8'd143 || s_axis_tready !== 1'b0) begin
          bad++;
          $display("FAIL bd_stall: got v=%b l=%b d=%h r=%b want 001 001 8f 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata[0], s_axis_tready);
        end
      end
    end
    @(posedge clk); #1;
    m_axis_tready = 3'b111;
    @(negedge clk);
    total++; if (m_axis_tvalid !== 3'b001) begin bad++; $display("FAIL bd_still: got %b want 001", m_axis_tvalid); end
    @(negedge clk);
    total++; if (m_axis_tvalid !== 3'b010 || m_axis_tdata[1] !== 8'd144 || m_axis_tlast !== 3'b000) begin bad++; $display("FAIL bd_next: got v=%b d=%h l=%b want 010 90 000", m_axis_tvalid, m_axis_tdata[1], m_axis_tlast); end
    @(negedge clk);
    total++; if (m_axis_tvalid !== 3'b000) begin bad++; $display("FAIL bd_empty: got %b want 000", m_axis_tvalid); end
  endtask

  task automatic test_midreset();
    int acc;
    logic [2:0] ev;
    do_reset();
    send(550, 3'b111, 1'b0, acc);
    @(negedge clk);
    total++; if (m_axis_tvalid !== 3'b010 || crop_idx !== 3'd1) begin bad++; $display("FAIL mr_pre: got v=%b crop=%0d want 010 1", m_axis_tvalid, crop_idx); end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    total++; if (m_axis_tvalid !== 3'b000 || s_axis_tready !== 1'b0 || crop_idx !== 3'd0) begin bad++; $display("FAIL mr_async: got v=%b r=%b crop=%0d want 000 0 0", m_axis_tvalid, s_axis_tready, crop_idx); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i <= 400; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = i < 400;
      s_axis_tdata = 8'(i + 7);
      @(negedge clk);
      if (i > 0) begin
        ev = ((i - 1) == 399) ? 3'b001 : 3'b000;
        total++;
        if (m_axis_tvalid !== 3'b001 || m_axis_tlast !== ev || m_axis_tdata[0] !== 8'(i + 6)) begin
          bad++;
          $display("FAIL mr_out: pix %0d got v=%b l=%b d=%h want 001 %b %h", i - 1, m_axis_tvalid, m_axis_tlast, m_axis_tdata[0], ev, 8'(i + 6));
        end
      end
    end
    @(negedge clk);
    total++; if (crop_idx !== 3'd1) begin bad++; $display("FAIL mr_crop: got %0d want 1", crop_idx); end
  endtask

  task automatic test_random();
    int acc;
    int f0;
    do_reset();
    f0 = fd_count;
    send(3600, 3'b111, 1'b1, acc);
    m_axis_tready = 3'b111;
    repeat (6) @(negedge clk);
    total++; if (acc != 3600) begin bad++; $display("FAIL rnd_accepted: got %0d want 3600", acc); end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL rnd_queue: got %0d left want 0", sbq.size()); end
    total++; if (fd_count - f0 != 3) begin bad++; $display("FAIL rnd_fd: got %0d want 3", fd_count - f0); end
    total++; if (crop_idx !== 3'd0 || s_axis_tready !== 1'b1) begin bad++; $display("FAIL rnd_idle: got crop=%0d r=%b want 0 1", crop_idx, s_axis_tready); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_boundary();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
